cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling engine between the CPU's cache arrays and the multi-cycle, pipelined main memory. It sits directly downstream of the CPU's instruction/data memory access path. On a cache miss it fetches one full 16-byte block as 8 sequential 16-bit words. Each returned word is handed to the cache data array, and the tag is written when the last word lands. The CPU stalls on fsm_busy.

Parameters:
ADDR_WIDTH, 16, byte address width.
WORDS_PER_BLOCK, 8, words per cache block; power of 2, word = 2 bytes.
OFFSET_BITS, 4, log2(bytes per block) = log2(WORDS_PER_BLOCK)+1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
miss_detected  input  1  cache reports a miss this cycle.
miss_address  input  ADDR_WIDTH  byte address that missed.
fsm_busy  output  1  fill in progress; CPU stalls.
mem_read_en  output  1  read request to memory this cycle.
memory_address  output  ADDR_WIDTH  request address, word aligned.
memory_data_valid  input  1  memory returns a word this cycle.
memory_data  input  16  returned word.
write_data_array  output  1  write fill_data into the data array at fill_address.
fill_address  output  ADDR_WIDTH  byte address of the returned word.
fill_data  output  16  equal to memory_data (combinational pass-through).
write_tag_array  output  1  write fill_tag into the tag array; single-cycle pulse.
fill_tag  output  ADDR_WIDTH-OFFSET_BITS  tag of the block being filled.

Behaviour:
- State register: IDLE and FILL. Registers: base (block address), issue_cnt (0..WORDS_PER_BLOCK), rcv_cnt (0..WORDS_PER_BLOCK-1).
- Reset (asynchronous, rst_n=0): state=IDLE, base=0, issue_cnt=0, rcv_cnt=0. All outputs 0 except fill_data, which follows memory_data.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall takes effect in the same cycle).
  - On miss_detected, at the next edge: base = {miss_address[15:4], 4'h0}, counters cleared, state goes to FILL.
  - memory_data_valid is ignored in IDLE: no array writes.
- FILL:
  - fsm_busy=1.
  - Issue: mem_read_en=1 while issue_cnt<WORDS_PER_BLOCK. memory_address = base + (issue_cnt<<1). issue_cnt increments each such cycle. There is no backpressure from memory: one request per cycle, 8 consecutive cycles.
  - When issue_cnt==WORDS_PER_BLOCK: mem_read_en=0 and memory_address=0.
  - Receive: write_data_array = memory_data_valid. fill_address = base + (rcv_cnt<<1). rcv_cnt increments on each valid.
  - Valids may overlap issue cycles. Returns are in order.
  - Last word (valid while rcv_cnt==WORDS_PER_BLOCK-1): write_tag_array=1 in the same cycle, fill_tag=base[15:4], and the next state is IDLE. fsm_busy is low in the following cycle unless a new miss_detected is present.
- Outside FILL: fill_address=0 and fill_tag=0.
- miss_detected during FILL is ignored. A miss still asserted after return to IDLE is accepted then, so back-to-back fills have exactly one IDLE cycle between them.
- Address arithmetic is within the block, so there is no carry into the tag. The top block 0xFFF0 fills 0xFFF0..0xFFFE with no wrap past the block.
- Reset mid-fill aborts immediately: no tag write, counters cleared. Any memory_data_valid that arrives afterwards falls in IDLE and is ignored.
- write_tag_array never asserts without 8 preceding or concurrent data writes for the same block.

Test Plan:
- Basic fill: reset, then miss_detected=1 with miss_address=0x1236 in cycle T, memory model with 4-cycle latency. Required: mem_read_en high in T+1..T+8 with addresses 0x1230,0x1232,...,0x123E. write_data_array in T+5..T+12 with matching fill_address. write_tag_array only in T+12, with fill_tag=0x123. fsm_busy high T..T+12 and low T+13.
- Data pass-through: memory returns 0xA000+i for word i. Required: fill_data equals each value in its write cycle, and all 8 words are written exactly once.
- Ignore stray traffic: memory_data_valid pulse in IDLE, and miss_detected=1 with address 0x4000 mid-fill. Required: no writes in IDLE, and the current fill completes with the original tag only.
- Back-to-back: miss_detected held high across two misses (0x0010, then 0x0020). Required: the second fill's first request comes 2 cycles after the first tag write, and its tag is 0x002.
- Reset mid-fill: rst_n low after 3 returned words, with the memory model still returning 5 more. Required: outputs go to 0 immediately, and there is no write_tag_array or write_data_array after reset.
- Boundary: miss at 0xFFFF. Required: requests 0xFFF0..0xFFFE, and fill_tag=0xFFF.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: on a miss, fetches one block from pipelined main
// memory as sequential words, streams each returned word into the data
// array and writes the tag together with the last word.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned OFFSET_BITS     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_detected,
  input  logic [ADDR_WIDTH-1:0]            miss_address,
  output logic                             fsm_busy,
  output logic                             mem_read_en,
  output logic [ADDR_WIDTH-1:0]            memory_address,
  input  logic                             memory_data_valid,
  input  logic [15:0]                      memory_data,
  output logic                             write_data_array,
  output logic [ADDR_WIDTH-1:0]            fill_address,
  output logic [15:0]                      fill_data,
  output logic                             write_tag_array,
  output logic [ADDR_WIDTH-OFFSET_BITS-1:0] fill_tag
);

  // Word index within a block (words are 2 bytes, so one bit fewer than the offset).
  localparam int unsigned IDX_W = OFFSET_BITS - 1;
  localparam logic [IDX_W:0]   ISSUE_DONE = (IDX_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] RCV_LAST   = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [IDX_W:0]          issue_cnt_q;
  logic [IDX_W-1:0]        rcv_cnt_q;

  logic                    in_fill;
  logic                    issuing;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   issue_off;
  logic [ADDR_WIDTH-1:0]   rcv_off;
  logic                    unused_offset;

  // The byte offset of the missing address is discarded: the whole block is fetched.
  assign unused_offset = ^miss_address[OFFSET_BITS-1:0];

  // Decode of the current fill position.
  always_comb begin
    in_fill   = (state_q == FILL);
    issuing   = in_fill && (issue_cnt_q != ISSUE_DONE);
    last_word = in_fill && memory_data_valid && (rcv_cnt_q == RCV_LAST);
    // base_q has a zero offset field, so OR-ing the word offset never carries into the tag.
    issue_off = ADDR_WIDTH'({issue_cnt_q[IDX_W-1:0], 1'b0});
    rcv_off   = ADDR_WIDTH'({rcv_cnt_q, 1'b0});
  end

  // State, block base and issue/receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            state_q     <= FILL;
            base_q      <= {miss_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
          end
        end
        FILL: begin
          if (issuing) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
          if (memory_data_valid) begin
            rcv_cnt_q <= rcv_cnt_q + 1'b1;
          end
          if (last_word) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs; the stall and array writes are combinational so they act in the same cycle.
  always_comb begin
    // Gated by rst_n so that every output is held low while reset is asserted.
    fsm_busy         = rst_n && (in_fill || miss_detected);
    mem_read_en      = issuing;
    memory_address   = issuing ? (base_q | issue_off) : '0;
    write_data_array = in_fill && memory_data_valid;
    fill_address     = in_fill ? (base_q | rcv_off) : '0;
    fill_data        = memory_data;
    write_tag_array  = last_word;
    fill_tag         = in_fill ? base_q[ADDR_WIDTH-1:OFFSET_BITS] : '0;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: stimulus pushes the expected requests, data
// writes and tag write (with their cycle numbers) into queues; a monitor
// pops and compares whenever the DUT presents one.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [11:0] fill_tag;

  cache_fill_fsm #(
    .ADDR_WIDTH     (16),
    .WORDS_PER_BLOCK(8),
    .OFFSET_BITS    (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .mem_read_en      (mem_read_en),
    .memory_address   (memory_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .write_data_array (write_data_array),
    .fill_address     (fill_address),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array),
    .fill_tag         (fill_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  exp_t        req_q[$];
  exp_t        wr_q[$];
  exp_t        tag_q[$];
  bit          busy_exp[int];
  bit          fill_win[int];
  logic [15:0] mem_img[65536];
  ret_t        mq[$];
  int          mem_lat = 4;
  bit          stray_valid = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void fail_event(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got 0x%0h, expected no event", name, cyc, act);
  endfunction

  // Memory model: captures each request and returns its word mem_lat cycles later, in order.
  always @(negedge clk) begin
    if (mem_read_en) mq.push_back(ret_t'{cyc + mem_lat, mem_img[memory_address]});
  end

  initial begin : mem_drv
    ret_t r;
    forever begin
      @(posedge clk);
      #2;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        memory_data_valid = 1'b1;
        memory_data       = r.data;
      end else begin
        memory_data_valid = stray_valid;
        memory_data       = 16'($urandom);
      end
    end
  end

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_busy;
    exp_busy = rst_n && (busy_exp.exists(cyc) || miss_detected);
    chk("busy", 32'(fsm_busy), 32'(exp_busy));

    while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
      e = req_q.pop_front();
      fail_event("req_missing", 32'(e.addr));
    end
    if (mem_read_en) begin
      if (req_q.size() == 0) fail_event("req_unexpected", 32'(memory_address));
      else begin
        e = req_q.pop_front();
        chk("req_cycle", 32'(cyc), 32'(e.cyc));
        chk("req_addr", 32'(memory_address), 32'(e.addr));
      end
    end else begin
      chk("req_addr_idle", 32'(memory_address), 32'h0);
    end

    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      e = wr_q.pop_front();
      fail_event("write_missing", 32'(e.addr));
    end
    if (write_data_array) begin
      if (wr_q.size() == 0) fail_event("write_unexpected", 32'(fill_address));
      else begin
        e = wr_q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
        chk("write_addr", 32'(fill_address), 32'(e.addr));
        chk("write_data", 32'(fill_data), 32'(e.data));
      end
    end

    while (tag_q.size() > 0 && tag_q[0].cyc < cyc) begin
      e = tag_q.pop_front();
      fail_event("tag_missing", 32'(e.addr));
    end
    if (write_tag_array) begin
      if (tag_q.size() == 0) fail_event("tag_unexpected", 32'(fill_tag));
      else begin
        e = tag_q.pop_front();
        chk("tag_cycle", 32'(cyc), 32'(e.cyc));
        chk("tag_value", 32'(fill_tag), 32'(e.addr));
      end
    end

    if (!fill_win.exists(cyc)) chk("idle_fill_outputs", 32'({fill_address, fill_tag}), 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a miss in the current cycle and queues the block's expected traffic.
  // hold keeps miss_detected high to the end; stray_miss raises a 0x4000 miss mid-fill;
  // abort_words>0 asserts reset right after that many words have been written.
  task automatic run_fill(input logic [15:0] addr, input int lat, input bit hold,
                          input bit stray_miss, input int abort_words);
    int          t;
    logic [15:0] base;
    logic [15:0] a;
    t             = cyc;
    base          = addr & 16'hFFF0;
    mem_lat       = lat;
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int i = 0; i < 8; i++) begin
      a = base + 16'(2 * i);
      req_q.push_back(exp_t'{t + 1 + i, a, 16'h0});
      wr_q.push_back(exp_t'{t + 1 + i + lat, a, mem_img[a]});
    end
    tag_q.push_back(exp_t'{t + 8 + lat, {4'h0, base[15:4]}, 16'h0});
    for (int k = t; k <= t + 8 + lat; k++) busy_exp[k] = 1'b1;
    for (int k = t + 1; k <= t + 8 + lat; k++) fill_win[k] = 1'b1;

    for (int k = 1; k <= 8 + lat; k++) begin
      tick();
      if (k == 1) miss_detected = hold;
      if (stray_miss && k == 3) begin
        miss_detected = 1'b1;
        miss_address  = 16'h4000;
      end
      if (stray_miss && k == 6) miss_detected = 1'b0;
      if (abort_words > 0 && k == abort_words + lat) begin
        @(negedge clk);
        #1;
        rst_n         = 1'b0;
        miss_detected = 1'b0;
        req_q.delete();
        wr_q.delete();
        tag_q.delete();
        for (int j = cyc; j <= cyc + 20; j++) begin
          busy_exp.delete(j);
          fill_win.delete(j);
        end
        #1;
        chk("rst_busy", 32'(fsm_busy), 32'h0);
        chk("rst_read_en", 32'(mem_read_en), 32'h0);
        chk("rst_mem_addr", 32'(memory_address), 32'h0);
        chk("rst_write_data", 32'(write_data_array), 32'h0);
        chk("rst_fill_addr", 32'(fill_address), 32'h0);
        chk("rst_write_tag", 32'(write_tag_array), 32'h0);
        chk("rst_fill_tag", 32'(fill_tag), 32'h0);
        chk("rst_fill_data", 32'(fill_data), 32'(memory_data));
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
    end
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin : stim
    int  gap;
    int  lat;
    int  abort;
    bit  hold;
    bit  stray;
    bit  prev_hold;
    for (int i = 0; i < 65536; i++) mem_img[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem_img[16'h1230 + 16'(2 * i)] = 16'hA000 + 16'(i);

    // Reset, including a miss presented while reset is held.
    rst_n = 1'b0;
    tick();
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    miss_detected = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fill, 4-cycle memory latency, data 0xA000+i.
    run_fill(16'h1236, 4, 1'b0, 1'b0, 0);

    // Stray memory valid in IDLE, then a fill with a stray miss in the middle.
    tick();
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    tick();
    run_fill(16'h2468, 3, 1'b0, 1'b1, 0);
    tick();

    // Back-to-back misses with miss_detected held.
    run_fill(16'h0010, 4, 1'b1, 1'b0, 0);
    run_fill(16'h0020, 4, 1'b0, 1'b0, 0);
    tick();

    // Reset after three returned words; the remaining returns must be ignored.
    run_fill(16'h5550, 4, 1'b0, 1'b0, 3);
    repeat (12) tick();

    // Top block of the address space.
    run_fill(16'hFFFF, 2, 1'b0, 1'b0, 0);

    // Randomized fills.
    prev_hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      gap = prev_hold ? 0 : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        stray_valid = ($urandom_range(0, 2) == 0);
        tick();
        stray_valid = 1'b0;
      end
      lat   = $urandom_range(1, 6);
      hold  = ($urandom_range(0, 3) == 0);
      stray = !hold && ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      run_fill(16'($urandom), lat, hold, stray, abort);
      if (abort > 0) begin
        repeat (lat + 10) tick();
        prev_hold = 1'b0;
      end else begin
        prev_hold = hold;
      end
    end
    miss_detected = 1'b0;
    repeat (5) tick();

    chk("leftover_expectations", 32'(req_q.size() + wr_q.size() + tag_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
